// File: rtl/qdiv_seq.sv
// Iterative restoring divider for sign-magnitude Q-format operands.
// Produces one quotient bit per clock and uses valid/ready handshakes on both sides.
module qdiv_seq #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic         ovf,
  output logic         div0
);

  localparam int ITER = N - 1 + Q;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    rem;
  logic [ITER-1:0] dvd;
  logic [ITER-1:0] quot;
  logic [N-2:0]    bmag;
  logic            sgn;

  logic [N-1:0]    rem_sh;
  logic [N:0]      diff;
  logic [N-1:0]    rem_nxt;
  logic [ITER-1:0] quot_nxt;
  logic [N-1:0]    res_q;
  logic            res_ovf;
  logic            accept;
  logic            b_zero;

  assign in_ready = (state == IDLE) & ~rst;
  assign accept   = in_valid & in_ready;
  assign b_zero   = (b[N-2:0] == {(N-1){1'b0}});

  // One restoring step plus final saturation / zero-sign cleanup of the quotient.
  always_comb begin
    rem_sh   = {rem[N-2:0], dvd[ITER-1]};
    diff     = {1'b0, rem_sh} - {2'b00, bmag};
    rem_nxt  = rem_sh;
    quot_nxt = {quot[ITER-2:0], 1'b0};
    res_q    = {N{1'b0}};
    res_ovf  = 1'b0;
    if (!diff[N]) begin
      rem_nxt  = diff[N-1:0];
      quot_nxt = {quot[ITER-2:0], 1'b1};
    end else begin
      rem_nxt  = rem_sh;
      quot_nxt = {quot[ITER-2:0], 1'b0};
    end
    // Any quotient bit at or above the sign position means the magnitude cannot be represented.
    if (|quot_nxt[ITER-1:N-1]) begin
      res_q   = {sgn, {(N-1){1'b1}}};
      res_ovf = 1'b1;
    end else if (quot_nxt[N-2:0] == {(N-1){1'b0}}) begin
      res_q   = {N{1'b0}};
      res_ovf = 1'b0;
    end else begin
      res_q   = {sgn, quot_nxt[N-2:0]};
      res_ovf = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (b_zero) begin
            state_nxt = DONE;
          end else begin
            state_nxt = CALC;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (cnt == CW'(1)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= {CW{1'b0}};
      rem       <= {N{1'b0}};
      dvd       <= {ITER{1'b0}};
      quot      <= {ITER{1'b0}};
      bmag      <= {(N-1){1'b0}};
      sgn       <= 1'b0;
      q         <= {N{1'b0}};
      ovf       <= 1'b0;
      div0      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            sgn  <= a[N-1] ^ b[N-1];
            bmag <= b[N-2:0];
            dvd  <= {a[N-2:0], {Q{1'b0}}};
            rem  <= {N{1'b0}};
            quot <= {ITER{1'b0}};
            cnt  <= CW'(ITER);
            if (b_zero) begin
              q         <= {1'b0, {(N-1){1'b1}}};
              ovf       <= 1'b0;
              div0      <= 1'b1;
              out_valid <= 1'b1;
            end
          end
        end
        CALC: begin
          rem  <= rem_nxt;
          quot <= quot_nxt;
          dvd  <= {dvd[ITER-2:0], 1'b0};
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            q         <= res_q;
            ovf       <= res_ovf;
            div0      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_qdiv_seq.sv
// Directed, table-driven bench for qdiv_seq with hand-written sequences for
// backpressure, back-to-back issue and mid-operation reset.
module tb_qdiv_seq;

  localparam int N    = 32;
  localparam int Q    = 15;
  localparam int LAT  = 47;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  q;
  logic          ovf;
  logic          div0;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ovf;
    logic        div0;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  qdiv_seq #(.Q(Q), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .ovf       (ovf),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Wait (bounded) for out_valid after the current edge; returns edges counted from acceptance.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_div(input string name, input vec_t v);
    int lat;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a        = v.a;
    b        = v.b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~v.a;
    b        = ~v.b;
    wait_valid(lat);
    chk({name, "_lat"}, lat, v.lat);
    chk({name, "_q"}, q, v.q);
    chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
    chk({name, "_div0"}, {31'd0, div0}, {31'd0, v.div0});
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk({name, "_one_cycle"}, {31'd0, out_valid}, 32'd0);
    end else begin
      chk({name, "_held"}, {31'd0, out_valid}, 32'd1);
    end
  endtask

  initial begin
    int   lat;
    vec_t v;

    vecs[0]  = '{32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0, LAT};
    vecs[1]  = '{32'h8001_8000, 32'h0001_0000, 32'h8000_C000, 1'b0, 1'b0, LAT};
    vecs[2]  = '{32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0, LAT};
    vecs[3]  = '{32'h8000_8000, 32'h8001_8000, 32'h0000_2AAA, 1'b0, 1'b0, LAT};
    vecs[4]  = '{32'h8000_0001, 32'h0001_8000, 32'h0000_0000, 1'b0, 1'b0, LAT};
    vecs[5]  = '{32'h0000_8000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1};
    vecs[6]  = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, LAT};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, LAT};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1};
    vecs[9]  = '{32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, LAT};
    vecs[10] = '{32'h0000_8000, 32'h8000_4000, 32'h8000_0000 | 32'h0001_0000, 1'b0, 1'b0, LAT};
    vecs[11] = '{32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 1'b0, 1'b0, LAT};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 32'd0;
    b         = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_div0", {31'd0, div0}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      do_div($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: result held for 10 cycles while a second request waits.
    out_ready = 1'b0;
    do_div("bp_first", vecs[0]);
    a        = 32'h0000_8000;
    b        = 32'h0001_8000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_q_%0d", i), q, 32'h0000_C000);
      chk($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_hs_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("bp_accept_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0000_0000;
    wait_valid(lat);
    chk("bp_second_lat", lat, LAT);
    chk("bp_second_q", q, 32'h0000_2AAA);
    chk("bp_second_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    #1;
    chk("bp_second_drop", {31'd0, out_valid}, 32'd0);

    // Reset at iteration 20 abandons the division.
    @(negedge clk);
    a        = 32'h0001_8000;
    b        = 32'h0001_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_q", q, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    chk("mid_rst_no_result", lat, 0);
    v = '{32'h8001_8000, 32'h0001_0000, 32'h8000_C000, 1'b0, 1'b0, LAT};
    do_div("post_rst", v);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/qdiv_seq.md
Name: qdiv_seq

Overview:
- Iterative signed fixed-point divider in the team's sign-magnitude Q format: bit N-1 is the sign, bits N-2:0 are the magnitude, and Q of those bits are fractional.
- It is the inverse arithmetic unit to the existing combinational Q-format adder/multiplier path. It feeds the datapath wherever a ratio is needed.
- It computes one quotient bit per clock using restoring division.
- It uses a valid/ready handshake on input and output, so it can sit between pipeline stages.

Parameters:
- Q, 15, number of fractional bits in operands and result.
- N, 32, total word width including the sign bit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair a/b is presented.
- in_ready  output  1  block can accept operands.
- a  input  N  dividend, sign-magnitude Q format.
- b  input  N  divisor, sign-magnitude Q format.
- out_valid  output  1  result q and flags are valid.
- out_ready  input  1  consumer accepts the result.
- q  output  N  quotient a/b, sign-magnitude Q format.
- ovf  output  1  magnitude saturated because of overflow.
- div0  output  1  divisor magnitude was zero.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state goes to IDLE; q=0, ovf=0, div0=0, out_valid=0.
- in_ready = (state==IDLE) & ~rst.
- Reset mid-operation: abandons the division with no result emitted. in_ready returns to 1 in the first cycle rst is low.
- States:
  - IDLE: on in_valid&in_ready, latch the operands.
    - If b[N-2:0]==0, go to DONE.
    - Otherwise, go to CALC with iteration counter = ITER = N-1+Q (46 at defaults).
  - CALC: each cycle, shift one dividend bit into the partial remainder and subtract |b|. If the result is non-negative, keep it and shift a 1 into the quotient; otherwise shift a 0. Decrement the counter. When the counter reaches 0, go to DONE.
  - DONE: out_valid=1, with q/ovf/div0 held stable. On out_ready, go to IDLE.
- Arithmetic:
  - Extended dividend = |a| << Q, width ITER bits; remainder register N bits.
  - Quotient magnitude M = floor(|a|*2^Q / |b|), ITER bits wide, truncated toward zero with no rounding.
  - Sign = a[N-1] XOR b[N-1].
- Overflow: if M >= 2^(N-1), the magnitude saturates to all ones, ovf=1, and the sign is kept (+max 0x7FFFFFFF, -max 0xFFFFFFFF).
- Divide by zero (|b|==0, regardless of b's sign bit):
  - q=0x7FFFFFFF (all-ones magnitude, positive), div0=1, ovf=0.
  - CALC is skipped.
  - 0/0 is handled the same way.
- No negative zero: if the final magnitude is 0, the sign bit is forced to 0. This covers |a|==0 and truncation to zero.
- Latency, counting rising edges from the acceptance edge:
  - Normal: out_valid is high after ITER+1 edges (47 at defaults).
  - div0: out_valid is high after 1 edge.
- Output handshake:
  - out_valid stays high until the edge where out_ready=1.
  - q and flags do not change while out_valid=1.
  - If out_ready is already high when DONE is entered, the result is valid for exactly one cycle.
- Simultaneous events: in_ready is 0 in DONE, so new operands presented during out_valid&out_ready are ignored. They are accepted at the earliest in the following IDLE cycle, which gives a minimum issue interval of ITER+2 cycles.
- Operand changes on a/b after acceptance have no effect.
- After DONE, q/ovf/div0 keep their last values through IDLE and CALC until the next result is written. They are meaningful only while out_valid=1.

Test Plan:
- Basic: a=0x00018000 (3.0), b=0x00010000 (2.0), out_ready=1 → q=0x0000C000 (1.5), ovf=0, div0=0, out_valid after 47 edges.
- Signs and truncation:
  - a=0x80018000 (-3.0), b=0x00010000 → q=0x8000C000.
  - a=0x00008000 (1.0), b=0x00018000 (3.0) → q=0x00002AAA.
  - a=0x80008000, b=0x80018000 → q=0x00002AAA.
- Zero cases:
  - a=0x80000001, b=0x00018000 → q=0x00000000, sign bit 0.
  - a=0x00008000, b=0x80000000 (negative zero) → q=0x7FFFFFFF, div0=1, out_valid 1 edge after acceptance.
- Overflow: a=0x7FFFFFFF, b=0x00000001 → q=0x7FFFFFFF, ovf=1; same with a=0xFFFFFFFF → q=0xFFFFFFFF, ovf=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 10 cycles after out_valid → q stable and in_ready=0 throughout, with a second in_valid held high.
  - Release out_ready → the second operand pair is accepted the cycle after the handshake and its result appears ITER+1 edges later.
- Reset: assert rst for 1 cycle at iteration 20 → out_valid stays 0, q=0, in_ready=1 the next cycle, and a fresh division completes correctly.
